// File: rtl/cache_axi_arbiter.sv
// Round-robin arbiter sharing one AXI line engine between I- and D-cache.
// The winner's request is latched on entry to BUSY; the engine sees only those registers.
module cache_axi_arbiter #(
    parameter int LINE_WORDS = 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      i_rd_req,
    input  logic [31:0]               i_addr,
    output logic                      i_gnt,
    output logic [32*LINE_WORDS-1:0]  i_rd_line,
    input  logic                      d_rd_req,
    input  logic                      d_wr_req,
    input  logic [31:0]               d_addr,
    input  logic [32*LINE_WORDS-1:0]  d_wr_line,
    output logic                      d_gnt,
    output logic [32*LINE_WORDS-1:0]  d_rd_line,
    output logic [31:0]               m_addr,
    output logic                      m_rd_req,
    output logic                      m_wr_req,
    output logic [32*LINE_WORDS-1:0]  m_wr_line,
    input  logic                      m_gnt,
    input  logic [32*LINE_WORDS-1:0]  m_rd_line,
    output logic [31:0]               i_xfer_cnt,
    output logic [31:0]               d_xfer_cnt
);
    localparam int LW = 32 * LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_d_q, last_d_d;
    logic [31:0]   addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [LW-1:0] line_q, line_d;
    logic [31:0]   icnt_q, icnt_d;
    logic [31:0]   dcnt_q, dcnt_d;
    logic          d_req;

    assign d_req = d_rd_req | d_wr_req;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            line_q   <= '0;
            icnt_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            line_q   <= line_d;
            icnt_q   <= icnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        line_d   = line_q;
        icnt_d   = icnt_q;
        dcnt_d   = dcnt_q;
        unique case (state_q)
            IDLE: begin
                // On a tie D wins unless it was served last.
                if (d_req && (!i_rd_req || !last_d_q)) begin
                    state_d = BUSY_D;
                    addr_d  = d_addr;
                    wr_d    = d_wr_req;
                    line_d  = d_wr_line;
                end else if (i_rd_req) begin
                    state_d = BUSY_I;
                    addr_d  = i_addr;
                    wr_d    = 1'b0;
                    line_d  = '0;
                end
            end
            BUSY_I: begin
                if (m_gnt) begin
                    state_d  = IDLE;
                    last_d_d = 1'b0;
                    icnt_d   = icnt_q + 32'd1;
                end
            end
            BUSY_D: begin
                if (m_gnt) begin
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                    dcnt_d   = dcnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        m_rd_req = 1'b0;
        m_wr_req = 1'b0;
        unique case (state_q)
            BUSY_I: begin
                m_rd_req = 1'b1;
                i_gnt    = m_gnt;
            end
            BUSY_D: begin
                m_rd_req = !wr_q;
                m_wr_req = wr_q;
                d_gnt    = m_gnt;
            end
            default: ;
        endcase
    end

    assign m_addr     = addr_q;
    assign m_wr_line  = line_q;
    assign i_rd_line  = m_rd_line;
    assign d_rd_line  = m_rd_line;
    assign i_xfer_cnt = icnt_q;
    assign d_xfer_cnt = dcnt_q;

endmodule
